// File: rtl/ik_pkg.sv
// Shared constants, joint vector types and controller states for the ik iteration datapath.
// The saturating magnitude helper lives here so the delta norm and later damping logic agree.
package ik_pkg;

    localparam int N_JOINTS = 6;
    localparam int ANG_W    = 21;
    localparam int DATA_W   = 36;
    localparam int ITER_W   = 8;

    typedef logic signed [ANG_W-1:0] angle_t;
    typedef angle_t [N_JOINTS-1:0]   joint_vec_t;
    typedef logic [ANG_W-1:0]        mag_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CHECK,
        FINISH
    } state_t;

    // Most negative value has no positive twin in ANG_W bits, so clamp it to the max positive.
    function automatic mag_t sat_abs(input angle_t a);
        mag_t r;
        if (a == {1'b1, {(ANG_W-1){1'b0}}}) begin
            r = {1'b0, {(ANG_W-1){1'b1}}};
        end else if (a < 0) begin
            r = mag_t'(-a);
        end else begin
            r = mag_t'(a);
        end
        return r;
    endfunction

    function automatic mag_t mag_max(input mag_t a, input mag_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ik_delta_norm.sv
// Combinational infinity norm of a delta vector: saturating |d| per element, then a
// binary max tree. Only the low ANG_W bits of each element carry the joint correction.
module ik_delta_norm
    import ik_pkg::*;
#(
    parameter int N_IN = N_JOINTS,
    parameter int IN_W = DATA_W
) (
    input  logic [N_IN*IN_W-1:0] delta,
    output mag_t                 max_mag
);

    localparam int LVLS   = $clog2(N_IN);
    localparam int LEAVES = 1 << LVLS;

    generate
        for (genvar gl = 0; gl <= LVLS; gl++) begin : g_lvl
            mag_t v [0:(LEAVES >> gl)-1];
            for (genvar gi = 0; gi < (LEAVES >> gl); gi++) begin : g_node
                if (gl == 0) begin : g_leaf
                    if (gi < N_IN) begin : g_used
                        angle_t d;
                        logic   unused_hi;
                        assign d         = angle_t'(delta[gi*IN_W +: ANG_W]);
                        assign unused_hi = ^delta[gi*IN_W+ANG_W +: IN_W-ANG_W];
                        assign v[gi]     = sat_abs(d);
                    end else begin : g_pad
                        assign v[gi] = '0;
                    end
                end else begin : g_max
                    assign v[gi] = mag_max(g_lvl[gl-1].v[2*gi], g_lvl[gl-1].v[2*gi+1]);
                end
            end
        end
    endgenerate

    assign max_mag = g_lvl[LVLS].v[0];

endmodule

// File: rtl/ik_iter_ctrl.sv
// Iteration controller around the ik_swift DLS step engine: loads, steps, feeds back
// dh_dyn_out, and stops on tolerance, iteration budget, watchdog expiry or abort.
module ik_iter_ctrl
    import ik_pkg::*;
#(
    parameter int RUN_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_JOINTS*ANG_W-1:0] theta_init,
    input  logic [6*DATA_W-1:0]       target_in,
    input  logic [ANG_W-1:0]          tol,
    input  logic [ITER_W-1:0]         iter_limit,
    output logic                      busy,
    output logic                      done,
    output logic                      converged,
    output logic                      timeout,
    output logic [ITER_W-1:0]         iter_count,
    output logic [N_JOINTS*ANG_W-1:0] theta_out,
    output logic                      swift_rst,
    output logic                      swift_en,
    output logic [N_JOINTS*ANG_W-1:0] swift_dh_in,
    output logic [6*DATA_W-1:0]       swift_target,
    input  logic                      swift_done,
    input  logic [N_JOINTS*ANG_W-1:0] swift_dh_out,
    input  logic [N_JOINTS*DATA_W-1:0] swift_delta
);

    localparam int WD_W = $clog2(RUN_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RUN_TIMEOUT - 1);

    state_t              state_reg;
    joint_vec_t          theta_reg;
    logic [6*DATA_W-1:0] target_reg;
    mag_t                tol_reg;
    logic [ITER_W-1:0]   limit_reg;
    logic [ITER_W-1:0]   iter_reg;
    logic [WD_W-1:0]     wd_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                conv_reg;
    logic                tmo_reg;
    logic                srst_reg;
    logic                sen_reg;

    mag_t                max_mag;
    logic [ITER_W-1:0]   iter_next;

    ik_delta_norm #(
        .N_IN (N_JOINTS),
        .IN_W (DATA_W)
    ) u_norm (
        .delta   (swift_delta),
        .max_mag (max_mag)
    );

    assign iter_next = (iter_reg == {ITER_W{1'b1}}) ? iter_reg : iter_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            theta_reg  <= '0;
            target_reg <= '0;
            tol_reg    <= '0;
            limit_reg  <= '0;
            iter_reg   <= '0;
            wd_reg     <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            conv_reg   <= 1'b0;
            tmo_reg    <= 1'b0;
            srst_reg   <= 1'b1;
            sen_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort && state_reg != IDLE) begin
                // Abandon the run quietly: results so far stay visible, engine held in reset.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                srst_reg  <= 1'b1;
                sen_reg   <= 1'b0;
                wd_reg    <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        srst_reg <= 1'b1;
                        sen_reg  <= 1'b0;
                        if (start) begin
                            theta_reg  <= theta_init;
                            target_reg <= target_in;
                            tol_reg    <= tol;
                            limit_reg  <= (iter_limit == '0) ? ITER_W'(1) : iter_limit;
                            iter_reg   <= '0;
                            conv_reg   <= 1'b0;
                            tmo_reg    <= 1'b0;
                            busy_reg   <= 1'b1;
                            state_reg  <= LOAD;
                        end
                    end
                    LOAD: begin
                        srst_reg  <= 1'b0;
                        sen_reg   <= 1'b1;
                        wd_reg    <= '0;
                        state_reg <= RUN;
                    end
                    RUN: begin
                        if (swift_done) begin
                            sen_reg   <= 1'b0;
                            state_reg <= CHECK;
                        end else if (wd_reg == WD_LAST) begin
                            sen_reg   <= 1'b0;
                            srst_reg  <= 1'b1;
                            tmo_reg   <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            wd_reg <= wd_reg + 1'b1;
                        end
                    end
                    CHECK: begin
                        theta_reg <= swift_dh_out;
                        iter_reg  <= iter_next;
                        srst_reg  <= 1'b1;
                        if (max_mag <= tol_reg) begin
                            conv_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else if (iter_next >= limit_reg) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            state_reg <= LOAD;
                        end
                    end
                    FINISH: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        srst_reg  <= 1'b1;
                        sen_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign converged    = conv_reg;
    assign timeout      = tmo_reg;
    assign iter_count   = iter_reg;
    assign theta_out    = theta_reg;
    assign swift_rst    = srst_reg;
    assign swift_en     = sen_reg;
    assign swift_dh_in  = theta_reg;
    assign swift_target = target_reg;

endmodule

// File: tb/tb_ik_iter_ctrl.sv
// Bench for ik_iter_ctrl: a stub ik_swift applies theta += delta from a per-iteration table,
// expected results are queued at start and compared when done pulses.
module tb_ik_iter_ctrl;
    import ik_pkg::*;

    localparam int TW = N_JOINTS * ANG_W;

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic                       abort;
    logic [TW-1:0]              theta_init;
    logic [6*DATA_W-1:0]        target_in;
    logic [ANG_W-1:0]           tol;
    logic [ITER_W-1:0]          iter_limit;
    logic                       busy;
    logic                       done;
    logic                       converged;
    logic                       timeout;
    logic [ITER_W-1:0]          iter_count;
    logic [TW-1:0]              theta_out;
    logic                       swift_rst;
    logic                       swift_en;
    logic [TW-1:0]              swift_dh_in;
    logic [6*DATA_W-1:0]        swift_target;
    logic                       swift_done;
    logic [TW-1:0]              swift_dh_out;
    logic [N_JOINTS*DATA_W-1:0] swift_delta;

    ik_iter_ctrl #(.RUN_TIMEOUT(255)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .theta_init   (theta_init),
        .target_in    (target_in),
        .tol          (tol),
        .iter_limit   (iter_limit),
        .busy         (busy),
        .done         (done),
        .converged    (converged),
        .timeout      (timeout),
        .iter_count   (iter_count),
        .theta_out    (theta_out),
        .swift_rst    (swift_rst),
        .swift_en     (swift_en),
        .swift_dh_in  (swift_dh_in),
        .swift_target (swift_target),
        .swift_done   (swift_done),
        .swift_dh_out (swift_dh_out),
        .swift_delta  (swift_delta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- stub ik_swift ----------------
    int   delta_tab [8][N_JOINTS];
    int   stub_cnt  = 0;
    int   stub_iter = 0;
    logic stub_done = 1'b0;
    logic stub_hang = 1'b0;
    logic stub_clr  = 1'b0;

    always @(posedge clk) begin
        if (stub_clr) stub_iter <= 0;
        else if (swift_rst && stub_done) stub_iter <= stub_iter + 1;
        if (swift_rst) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (swift_en && !stub_done && !stub_hang) begin
            stub_cnt <= stub_cnt + 1;
            // done high during the 249th enabled cycle
            if (stub_cnt == 247) stub_done <= 1'b1;
        end
    end
    assign swift_done = stub_done;

    always_comb begin
        int idx;
        int dv;
        swift_delta  = '0;
        swift_dh_out = '0;
        idx = (stub_iter > 7) ? 7 : stub_iter;
        for (int j = 0; j < N_JOINTS; j++) begin
            dv = delta_tab[idx][j];
            swift_delta[j*DATA_W +: DATA_W] = DATA_W'(dv);
            swift_dh_out[j*ANG_W +: ANG_W]  = swift_dh_in[j*ANG_W +: ANG_W] + ANG_W'(dv);
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int            lat;
        bit            conv;
        bit            tmo;
        int            iters;
        logic [TW-1:0] theta;
    } exp_t;

    exp_t sb[$];
    int   start_cyc = 0;
    int   done_cnt  = 0;

    always @(negedge clk) begin
        if (done) begin
            done_cnt <= done_cnt + 1;
            if (sb.size() == 0) begin
                check_val("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("done: lat=%0d conv=%0b tmo=%0b iters=%0d", cyc - start_cyc, converged, timeout, iter_count);
                check_val("done_latency", cyc - start_cyc, e.lat);
                check_val("converged", converged, e.conv);
                check_val("timeout", timeout, e.tmo);
                check_val("iter_count", iter_count, e.iters);
                check_val("theta_out", theta_out, e.theta);
                check_val("busy_at_done", busy, 0);
            end
        end
    end

    function automatic logic [TW-1:0] mk_theta(input int base);
        logic [TW-1:0] r;
        for (int j = 0; j < N_JOINTS; j++) r[j*ANG_W +: ANG_W] = ANG_W'(base + 1111 * j - 2000);
        return r;
    endfunction

    function automatic logic [TW-1:0] exp_theta(input logic [TW-1:0] th0, input int n);
        logic [TW-1:0]    r;
        logic [ANG_W-1:0] a;
        r = th0;
        for (int it = 0; it < n; it++) begin
            for (int j = 0; j < N_JOINTS; j++) begin
                a = r[j*ANG_W +: ANG_W] + ANG_W'(delta_tab[it][j]);
                r[j*ANG_W +: ANG_W] = a;
            end
        end
        return r;
    endfunction

    task automatic set_rows(input int v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < N_JOINTS; j++) delta_tab[i][j] = v;
    endtask

    task automatic clear_stub();
        @(negedge clk);
        stub_clr = 1'b1;
        @(negedge clk);
        stub_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check_val("done_wait_expired", 0, 1);
    endtask

    task automatic kick(input logic [TW-1:0] th0, input int limit, input int tolv);
        logic [6*DATA_W-1:0] tgt;
        tgt = {6{DATA_W'($urandom)}};
        @(negedge clk);
        theta_init = th0;
        target_in  = tgt;
        tol        = ANG_W'(tolv);
        iter_limit = ITER_W'(limit);
        start      = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        check_val("busy_after_start", busy, 1);
        check_val("conv_cleared", converged, 0);
        check_val("tmo_cleared", timeout, 0);
        check_val("load_swift_rst", swift_rst, 1);
        check_val("target_held", swift_target, tgt);
    endtask

    task automatic run_case(input logic [TW-1:0] th0, input int limit, input int tolv,
                            input int n_it, input bit conv, input bit tmo);
        exp_t e;
        int   nlat;
        clear_stub();
        nlat    = tmo ? 256 : 251 * n_it;
        e.lat   = nlat;
        e.conv  = conv;
        e.tmo   = tmo;
        e.iters = n_it;
        e.theta = exp_theta(th0, n_it);
        sb.push_back(e);
        kick(th0, limit, tolv);
        wait_done(nlat + 300);
    endtask

    initial begin
        logic [TW-1:0] th0;
        logic [TW-1:0] th1;
        int            dc;

        rst        = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        theta_init = '0;
        target_in  = '0;
        tol        = '0;
        iter_limit = '0;
        set_rows(0);
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_swift_rst", swift_rst, 1);
        check_val("rst_swift_en", swift_en, 0);
        check_val("rst_theta_out", theta_out, 0);
        rst = 1'b1;
        @(negedge clk);
        check_val("idle_done", done, 0);
        check_val("idle_iter", iter_count, 0);

        // zero deltas converge on the first step
        th0 = mk_theta(5000);
        set_rows(0);
        run_case(th0, 8, 10, 1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check_val("conv_persists", converged, 1);

        // shrinking deltas converge after four steps
        set_rows(0);
        for (int j = 0; j < N_JOINTS; j++) begin
            delta_tab[0][j] = 4000;
            delta_tab[1][j] = 2000;
            delta_tab[2][j] = 1000;
            delta_tab[3][j] = 500;
        end
        th0 = mk_theta(-30000);
        run_case(th0, 8, 600, 4, 1'b1, 1'b0);

        // constant large deltas exhaust the budget; limit 0 acts as 1
        set_rows(5000);
        th0 = mk_theta(123);
        run_case(th0, 3, 10, 3, 1'b0, 1'b0);
        run_case(th0, 0, 10, 1, 1'b0, 1'b0);

        // engine never finishes
        stub_hang = 1'b1;
        run_case(th0, 8, 10, 0, 1'b0, 1'b1);
        stub_hang = 1'b0;

        // most negative delta saturates to 2^20-1
        set_rows(0);
        delta_tab[0][2] = -(1 << 20);
        th0 = mk_theta(777);
        run_case(th0, 1, (1 << 20) - 2, 1, 1'b0, 1'b0);
        run_case(th0, 1, (1 << 20) - 1, 1, 1'b1, 1'b0);

        // abort during the second RUN
        set_rows(5000);
        th0 = mk_theta(42);
        clear_stub();
        kick(th0, 8, 10);
        dc = done_cnt;
        while (cyc < start_cyc + 351) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        $display("abort: busy=%0b en=%0b iters=%0d", busy, swift_en, iter_count);
        check_val("abort_busy", busy, 0);
        check_val("abort_swift_en", swift_en, 0);
        check_val("abort_swift_rst", swift_rst, 1);
        check_val("abort_iter", iter_count, 1);
        check_val("abort_theta", theta_out, exp_theta(th0, 1));
        repeat (600) @(negedge clk);
        check_val("abort_no_done", done_cnt, dc);

        // asynchronous reset in the middle of RUN
        clear_stub();
        kick(th0, 8, 10);
        repeat (400) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        $display("async reset: busy=%0b srst=%0b iters=%0d", busy, swift_rst, iter_count);
        check_val("arst_busy", busy, 0);
        check_val("arst_swift_rst", swift_rst, 1);
        check_val("arst_swift_en", swift_en, 0);
        check_val("arst_iter", iter_count, 0);
        check_val("arst_theta", theta_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start held high through a run is not re-sampled until IDLE
        set_rows(0);
        th0 = mk_theta(9000);
        th1 = mk_theta(-9000);
        clear_stub();
        begin
            exp_t e;
            e.lat   = 251;
            e.conv  = 1'b1;
            e.tmo   = 1'b0;
            e.iters = 1;
            e.theta = th0;
            sb.push_back(e);
        end
        @(negedge clk);
        theta_init = th0;
        tol        = ANG_W'(10);
        iter_limit = ITER_W'(1);
        start      = 1'b1;
        @(negedge clk);
        start_cyc  = cyc;
        theta_init = th1;
        wait_done(600);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_val("held_start_idle", busy, 0);

        repeat (5) @(negedge clk);
        check_val("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/ik_iter_ctrl.md
Name: ik_iter_ctrl

Overview:
- Iteration controller wrapped around the ik_swift DLS step engine.
- Loads initial joint parameters and the Cartesian target, runs one ik_swift step at a time, and feeds each step's dh_dyn_out back as the next dh_dyn_in.
- Stops when the largest per-joint correction is within tolerance, or when the iteration budget is spent.
- Reports final joint values, iteration count, convergence and timeout to the host register layer.

Parameters:
- N_JOINTS, 6, number of joints (fixed by ik_swift).
- ANG_W, 21, joint value width, signed Q5.16.
- DATA_W, 36, target/delta element width, signed.
- RUN_TIMEOUT, 255, maximum cycles in RUN waiting for swift_done.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- abort  in  1  level; forces return to IDLE.
- theta_init  in  N_JOINTS*ANG_W  initial dh_dyn values, joint 0 in LSBs.
- target_in  in  6*DATA_W  {k,j,i,z,y,x} target.
- tol  in  ANG_W  unsigned convergence threshold.
- iter_limit  in  8  maximum iterations; 0 is treated as 1.
- busy  out  1  high from LOAD through CHECK.
- done  out  1  one-cycle completion pulse.
- converged  out  1  valid from done until next start.
- timeout  out  1  ik_swift failed to finish; valid from done until next start.
- iter_count  out  8  iterations completed.
- theta_out  out  N_JOINTS*ANG_W  latest joint values.
- swift_rst  out  1  active-high synchronous reset to ik_swift.
- swift_en  out  1  ik_swift enable.
- swift_dh_in  out  N_JOINTS*ANG_W  drives ik_swift dh_dyn_in.
- swift_target  out  6*DATA_W  drives ik_swift target.
- swift_done  in  1  ik_swift done.
- swift_dh_out  in  N_JOINTS*ANG_W  ik_swift dh_dyn_out.
- swift_delta  in  N_JOINTS*DATA_W  ik_swift delta.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 except swift_rst=1; theta regs, iter_count and watchdog cleared.
- IDLE: swift_en=0, swift_rst=1.
  - start=1 → capture theta_init into the theta regs and target_in into the target reg.
  - Clear iter_count, converged and timeout.
  - Go to LOAD.
- LOAD (1 cycle): swift_rst=1, swift_en=0; swift_dh_in=theta regs. This clears ik_swift's count and done. → RUN.
- RUN: swift_rst=0, swift_en=1; swift_dh_in and swift_target held stable; watchdog increments each cycle.
  - swift_done=1 → CHECK.
  - Watchdog reaches RUN_TIMEOUT → timeout=1, go to FINISH.
  - swift_done wins over a simultaneous watchdog expiry.
- CHECK (1 cycle): swift_en=0.
  - For each joint, d = swift_delta[j][ANG_W-1:0] as signed.
  - |d| is computed with saturation: -2^20 → 2^20-1.
  - m = max |d| over all joints.
  - theta regs ← swift_dh_out; iter_count++.
  - If m <= tol (unsigned compare), set converged=1 and go to FINISH.
  - Else, if iter_count (after the increment) >= max(iter_limit,1), go to FINISH with converged=0.
  - Else go to LOAD.
- FINISH (1 cycle): done=1, busy=0 → IDLE.
- theta_out always reflects the theta regs.
- start while busy: ignored.
- abort in any non-IDLE state: next state IDLE, no done pulse; iter_count and theta_out keep their current values.
- Nominal iteration with the real ik_swift (249 enabled cycles to done): 1 LOAD + 249 RUN + 1 CHECK = 251 cycles. done therefore pulses 251*N+1 cycles after the start edge.
- iter_count saturates at 255; unreachable given the 8-bit limit.

Decomposition:
- Package ik_pkg: ANG_W/DATA_W/N_JOINTS constants, typedef angle_t (signed ANG_W), typedef joint_vec_t ([N_JOINTS-1:0] angle_t), and the state enum {IDLE, LOAD, RUN, CHECK, FINISH}.
- One sub-module, ik_delta_norm: combinational saturating abs plus a max-reduction tree that returns m. It is reused by the later adaptive-damping block.

Test Plan:
- Stub ik_swift raises done after 249 enabled cycles with delta all 0. start with tol=10, iter_limit=8 → done at cycle 252; converged=1, iter_count=1, theta_out=stub dh_out.
- Stub deltas shrink 4000,2000,1000,500 (stub applies theta+=delta), tol=600 → converged after iteration 4; iter_count=4; theta_out = theta_init + 7500 per joint.
- Deltas constant 5000, iter_limit=3 → done after 3 iterations; converged=0, timeout=0, iter_count=3. A second run with iter_limit=0 stops after 1 iteration.
- Stub never raises done → done at LOAD+255 RUN cycles; timeout=1, converged=0, iter_count=0.
- Delta joint 2 = -2^20, tol=2^20-2 → not converged (saturated abs). Same case with tol=2^20-1 → converged.
- abort mid-RUN of iteration 2 → IDLE next cycle, no done, swift_en=0, iter_count=1. rst low mid-RUN → all outputs 0 and swift_rst=1 immediately. A start held high throughout a run is not re-accepted until IDLE.
